mod_counter_chain: RTL and testbench

Parametrised multi-digit modulo counter: DIGITS cascaded digits, each counting modulo MOD in BITS bits, with enable, up/down direction, synchronous clear, parallel load, optional saturation and registered wrap flags. Generalises the team's single-digit mod-N counter for multi-digit timers, BCD event counters and display drivers. Chains of instances cascade through `tc`.

---
 rtl/mod_counter_chain_pkg.sv | 15 +
 rtl/mod_counter_chain_digit.sv | 38 +++
 rtl/mod_counter_chain.sv | 77 +++++++
 tb/tb_mod_counter_chain.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mod_counter_chain_pkg.sv
// Shared constants and helpers for the cascaded modulo counter.
package counter_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Number of bits needed to hold the values 0..m-1.
  function automatic int clog2_mod(input int m);
    int r;
    r = 0;
    for (int v = m - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/mod_counter_chain_digit.sv
// One modulo-MOD digit: clear, load with range check, and wrap-around step.
module mod_digit
  import counter_pkg::*;
#(
  parameter int MOD  = 10,
  parameter int BITS = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            step_in,
  input  logic            up,
  input  logic            clr,
  input  logic            load,
  input  logic [BITS-1:0] load_digit,
  output logic [BITS-1:0] digit,
  output logic            at_end
);

  localparam logic [BITS-1:0] TOP_D = BITS'(MOD - 1);
  localparam logic [BITS:0]   MOD_W = (BITS + 1)'(MOD);

  // at_end depends on direction: the digit that would wrap on this step
  assign at_end = (up == DIR_UP) ? (digit == TOP_D) : (digit == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      digit <= '0;
    end else if (clr) begin
      digit <= '0;
    end else if (load) begin
      digit <= ({1'b0, load_digit} >= MOD_W) ? '0 : load_digit;
    end else if (step_in) begin
      if (up == DIR_UP) digit <= at_end ? '0 : digit + 1'b1;
      else              digit <= at_end ? TOP_D : digit - 1'b1;
    end
  end

endmodule

// File: rtl/mod_counter_chain.sv
// Multi-digit modulo counter: DIGITS cascaded mod_digit instances with
// optional saturation, registered wrap flags and a cascade terminal count.
module mod_counter_chain
  import counter_pkg::*;
#(
  parameter int MOD      = 10,
  parameter int BITS     = 4,
  parameter int DIGITS   = 2,
  parameter int SATURATE = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   up,
  input  logic                   clr,
  input  logic                   load,
  input  logic [DIGITS*BITS-1:0] load_val,
  output logic [DIGITS*BITS-1:0] count_out,
  output logic                   carry_out,
  output logic                   borrow_out,
  output logic                   tc
);

  if (clog2_mod(MOD) > BITS || MOD < 2 || DIGITS < 1) begin : g_bad_params
    $error("mod_counter_chain: need 2 <= MOD <= 2**BITS and DIGITS >= 1");
  end

  localparam logic SAT = (SATURATE != 0);

  logic [DIGITS-1:0] at_end;
  logic [DIGITS-1:0] step;
  logic              full;
  logic              step_en;

  // every digit at its end value means MAX going up or ZERO going down
  assign full    = &at_end;
  assign tc      = en & full;
  assign step_en = en & ~(SAT & full);

  always_comb begin
    logic run;
    run  = step_en;
    step = '0;
    for (int i = 0; i < DIGITS; i++) begin
      step[i] = run;
      run     = run & at_end[i];
    end
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    mod_digit #(
      .MOD (MOD),
      .BITS(BITS)
    ) u_digit (
      .clk       (clk),
      .rst       (rst),
      .step_in   (step[i]),
      .up        (up),
      .clr       (clr),
      .load      (load),
      .load_digit(load_val[i*BITS +: BITS]),
      .digit     (count_out[i*BITS +: BITS]),
      .at_end    (at_end[i])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      carry_out  <= 1'b0;
      borrow_out <= 1'b0;
    end else begin
      carry_out  <= !clr && !load && en && (up == DIR_UP) && full;
      borrow_out <= !clr && !load && en && (up == DIR_DN) && full;
    end
  end

endmodule

// File: tb/tb_mod_counter_chain.sv
// Bench for mod_counter_chain: a wrapping and a saturating instance share
// stimulus and are checked against an integer-valued reference model.
module tb_mod_counter_chain;

  localparam int MOD    = 10;
  localparam int BITS   = 4;
  localparam int DIGITS = 2;
  localparam int W      = DIGITS * BITS;
  localparam int TOP    = MOD ** DIGITS - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0, up = 1'b1, clr = 1'b0, load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] count_w, count_s;
  logic         carry_w, borrow_w, tc_w;
  logic         carry_s, borrow_s, tc_s;

  int n_cmp = 0;
  int n_bad = 0;

  int vw = 0, vs = 0;
  bit cw = 0, bw = 0, cs = 0, bs = 0;

  always #5 clk = ~clk;

  mod_counter_chain #(.MOD(MOD), .BITS(BITS), .DIGITS(DIGITS), .SATURATE(0)) dut_w (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .count_out(count_w), .carry_out(carry_w),
    .borrow_out(borrow_w), .tc(tc_w)
  );

  mod_counter_chain #(.MOD(MOD), .BITS(BITS), .DIGITS(DIGITS), .SATURATE(1)) dut_s (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .count_out(count_s), .carry_out(carry_s),
    .borrow_out(borrow_s), .tc(tc_s)
  );

  function automatic logic [W-1:0] pack(input int v);
    logic [W-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int d = 0; d < DIGITS; d++) begin
      r[d*BITS +: BITS] = BITS'(x % MOD);
      x = x / MOD;
    end
    return r;
  endfunction

  function automatic int unpack_load(input logic [W-1:0] lv);
    int v, w, f;
    v = 0;
    w = 1;
    for (int d = 0; d < DIGITS; d++) begin
      f = int'(lv[d*BITS +: BITS]);
      if (f >= MOD) f = 0;
      v += f * w;
      w *= MOD;
    end
    return v;
  endfunction

  task automatic ref_step(input int v_in, input bit sat, output int v, output bit c, output bit b);
    v = v_in;
    c = 0;
    b = 0;
    if (clr) v = 0;
    else if (load) v = unpack_load(load_val);
    else if (en) begin
      if (up) begin
        if (v_in == TOP) begin c = 1; v = sat ? TOP : 0; end
        else v = v_in + 1;
      end else begin
        if (v_in == 0) begin b = 1; v = sat ? 0 : TOP; end
        else v = v_in - 1;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_tc(input int v);
    return en && (up ? (v == TOP) : (v == 0));
  endfunction

  task automatic check_outputs();
    check("count_w", 32'(count_w), 32'(pack(vw)));
    check("carry_w", 32'(carry_w), 32'(cw));
    check("borrow_w", 32'(borrow_w), 32'(bw));
    check("count_s", 32'(count_s), 32'(pack(vs)));
    check("carry_s", 32'(carry_s), 32'(cs));
    check("borrow_s", 32'(borrow_s), 32'(bs));
  endtask

  // drive at the falling edge, check tc, clock once, check registered outputs
  task automatic cyc(input logic c, input logic l, input logic e, input logic u, input logic [W-1:0] lv);
    int nv;
    bit nc, nb;
    clr = c; load = l; en = e; up = u; load_val = lv;
    #1;
    check("tc_w", 32'(tc_w), 32'(exp_tc(vw)));
    check("tc_s", 32'(tc_s), 32'(exp_tc(vs)));
    @(posedge clk);
    ref_step(vw, 0, nv, nc, nb); vw = nv; cw = nc; bw = nb;
    ref_step(vs, 1, nv, nc, nb); vs = nv; cs = nc; bs = nb;
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  initial begin
    #12;
    check("reset_count", 32'(count_w), 32'h0);
    check("reset_flags", 32'({carry_w, borrow_w, carry_s, borrow_s}), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // up wrap
    cyc(0, 1, 0, 1, 8'h98);
    cyc(0, 0, 1, 1, 8'h00);
    check("up_wrap_99", 32'(count_w), 32'h99);
    cyc(0, 0, 1, 1, 8'h00);
    check("up_wrap_00", 32'({count_w, carry_w}), 32'({8'h00, 1'b1}));
    cyc(0, 0, 1, 1, 8'h00);
    check("up_wrap_01", 32'({count_w, carry_w}), 32'({8'h01, 1'b0}));

    // down wrap
    cyc(0, 1, 0, 0, 8'h01);
    cyc(0, 0, 1, 0, 8'h00);
    cyc(0, 0, 1, 0, 8'h00);
    check("down_wrap_99", 32'({count_w, borrow_w}), 32'({8'h99, 1'b1}));
    cyc(0, 0, 1, 0, 8'h00);
    check("down_wrap_98", 32'(count_w), 32'h98);

    // load validation and hold
    cyc(0, 1, 0, 1, 8'h5A);
    check("load_5a", 32'(count_w), 32'h50);
    cyc(0, 0, 1, 1, 8'h00);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, i[0], 8'h00);
    check("hold_51", 32'({count_w, carry_w, borrow_w}), 32'({8'h51, 2'b00}));

    // priority
    cyc(1, 1, 1, 1, 8'h37);
    check("prio_clr", 32'(count_w), 32'h00);
    cyc(0, 1, 1, 1, 8'h37);
    check("prio_load", 32'(count_w), 32'h37);

    // async reset between edges
    cyc(0, 1, 0, 1, 8'h42);
    rst = 1'b0;
    #1;
    check("async_rst", 32'({count_w, carry_w, borrow_w, count_s}), 32'h0);
    vw = 0; vs = 0; cw = 0; bw = 0; cs = 0; bs = 0;
    rst = 1'b1;
    cyc(0, 0, 1, 1, 8'h00);
    check("post_rst", 32'(count_w), 32'h01);

    // saturation
    cyc(0, 1, 0, 1, 8'h99);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, 1, 8'h00);
      check("sat_hold", 32'({count_s, carry_s}), 32'({8'h99, 1'b1}));
    end
    cyc(0, 0, 1, 0, 8'h00);
    check("sat_down", 32'({count_s, carry_s}), 32'({8'h98, 1'b0}));
    cyc(1, 0, 0, 0, 8'h00);
    cyc(0, 0, 1, 0, 8'h00);
    check("sat_zero", 32'({count_s, borrow_s}), 32'({8'h00, 1'b1}));

    // randomized
    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      cyc(r < 3, (r >= 3 && r < 12) || ($urandom_range(0, 19) == 0),
          $urandom_range(0, 9) < 7, 1'($urandom),
          (r < 40) ? ((i[0]) ? 8'h99 : 8'h00) : W'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
